// File: rtl/sensor_condicionador.sv
// rtl/sensor_condicionador.sv - float-switch synchroniser, debouncer and tank-consistency fault latch (optional FAULT_SAFE_EN)
module sensor_condicionador #(
    parameter int DEBOUNCE     = 8,
    parameter int FAULT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_s1,
    input  logic raw_s2,
    input  logic raw_s3,
    input  logic raw_s4,
    input  logic clr_fault,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic s4,
    output logic fault_inf,
    output logic fault_sup,
    output logic sensores_ok
);

    localparam int DW = $clog2(DEBOUNCE);
    localparam int FW = $clog2(FAULT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE - 1);
    localparam logic [FW-1:0] FC_MAX   = FW'(FAULT_CYCLES);
    localparam logic [FW-1:0] FC_ARMED = FW'(FAULT_CYCLES - 1);

    // Bit 0..3 map to s1..s4.
    logic [3:0]    raw;
    logic [3:0]    sync1_q, sync2_q;
    logic [3:0]    filt_q, filt_d;
    logic [DW-1:0] cnt_q [4];
    logic [DW-1:0] cnt_d [4];

    logic [FW-1:0] fcnt_inf_q, fcnt_inf_d, fcnt_sup_q, fcnt_sup_d;
    logic          fault_inf_q, fault_inf_d, fault_sup_q, fault_sup_d;
    logic          ok_q, ok_d;
    logic          incons_inf, incons_sup;
    logic [3:0]    s_out;

    assign raw = {raw_s4, raw_s3, raw_s2, raw_s1};

    // Two-flop synchroniser for the asynchronous switch inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: a channel flips only after DEBOUNCE consecutive mismatching samples.
    always_comb begin
        filt_d = filt_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    filt_d[i] = ~filt_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            filt_q <= filt_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign incons_inf = filt_q[1] & ~filt_q[0];
    assign incons_sup = filt_q[3] & ~filt_q[2];

    // Persistence counters and fault latches; a clear only takes when the tank reads consistent.
    always_comb begin
        fcnt_inf_d  = '0;
        fcnt_sup_d  = '0;
        fault_inf_d = fault_inf_q;
        fault_sup_d = fault_sup_q;
        if (incons_inf) begin
            fcnt_inf_d = (fcnt_inf_q == FC_MAX) ? fcnt_inf_q : fcnt_inf_q + 1'b1;
            if (fcnt_inf_q >= FC_ARMED) fault_inf_d = 1'b1;
        end else if (clr_fault) begin
            fault_inf_d = 1'b0;
        end
        if (incons_sup) begin
            fcnt_sup_d = (fcnt_sup_q == FC_MAX) ? fcnt_sup_q : fcnt_sup_q + 1'b1;
            if (fcnt_sup_q >= FC_ARMED) fault_sup_d = 1'b1;
        end else if (clr_fault) begin
            fault_sup_d = 1'b0;
        end
        ok_d = ~(fault_inf_d | fault_sup_d);
    end

    // Fault state registers; sensores_ok tracks the next-state flags so it moves with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_inf_q  <= '0;
            fcnt_sup_q  <= '0;
            fault_inf_q <= 1'b0;
            fault_sup_q <= 1'b0;
            ok_q        <= 1'b1;
        end else begin
            fcnt_inf_q  <= fcnt_inf_d;
            fcnt_sup_q  <= fcnt_sup_d;
            fault_inf_q <= fault_inf_d;
            fault_sup_q <= fault_sup_d;
            ok_q        <= ok_d;
        end
    end

`ifdef FAULT_SAFE_EN
    // Report both tanks full while any fault is latched so the controller idles both motors.
    assign s_out = (fault_inf_q | fault_sup_q) ? 4'hF : filt_q;
`else
    assign s_out = filt_q;
`endif

    assign s1          = s_out[0];
    assign s2          = s_out[1];
    assign s3          = s_out[2];
    assign s4          = s_out[3];
    assign fault_inf   = fault_inf_q;
    assign fault_sup   = fault_sup_q;
    assign sensores_ok = ok_q;

endmodule

// File: tb/tb_sensor_condicionador.sv
// tb/tb_sensor_condicionador.sv - directed self-checking bench for sensor_condicionador
module tb_sensor_condicionador;

`ifdef FAULT_SAFE_EN
    localparam bit SAFE = 1'b1;
`else
    localparam bit SAFE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic raw_s1 = 1'b0, raw_s2 = 1'b0, raw_s3 = 1'b0, raw_s4 = 1'b0;
    logic clr_fault = 1'b0;
    logic s1, s2, s3, s4, fault_inf, fault_sup, sensores_ok;

    int n_checks = 0;
    int n_fails  = 0;

    sensor_condicionador #(.DEBOUNCE(8), .FAULT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .raw_s1(raw_s1), .raw_s2(raw_s2), .raw_s3(raw_s3), .raw_s4(raw_s4),
        .clr_fault(clr_fault),
        .s1(s1), .s2(s2), .s3(s3), .s4(s4),
        .fault_inf(fault_inf), .fault_sup(fault_sup), .sensores_ok(sensores_ok)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Observed vector is {s1,s2,s3,s4,fault_inf,fault_sup,sensores_ok}.
    task automatic chk(input string tag, input logic [6:0] exp);
        logic [6:0] obs;
        obs = {s1, s2, s3, s4, fault_inf, fault_sup, sensores_ok};
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        raw_s1 = 0; raw_s2 = 0; raw_s3 = 0; raw_s4 = 0; clr_fault = 0;
        rst = 1;
        tick(2);
        rst = 0;
    endtask

    initial begin
        #1;
        // 1: reset with toggling inputs, then quiet release
        for (int i = 0; i < 6; i++) begin
            raw_s1 = i[0]; raw_s2 = ~i[0]; raw_s3 = i[0]; raw_s4 = ~i[0];
            tick(1);
            chk("reset_hold", 7'b0000001);
        end
        raw_s1 = 0; raw_s2 = 0; raw_s3 = 0; raw_s4 = 0;
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("post_release", 7'b0000001);
        end

        // 2: s1 rises on edge 10 only
        raw_s1 = 1;
        tick(9);  chk("s1_edge9", 7'b0000001);
        tick(1);  chk("s1_edge10", 7'b1000001);
        tick(5);  chk("s1_hold", 7'b1000001);

        // 3: short glitch rejected, long pulse accepted
        do_reset();
        raw_s3 = 1; tick(5); raw_s3 = 0;
        tick(15); chk("s3_glitch", 7'b0000001);
        raw_s3 = 1;
        tick(9);  chk("s3_edge9", 7'b0000001);
        tick(1);  chk("s3_edge10", 7'b0010001);
        tick(2);  raw_s3 = 0;

        // 4: lower-tank inconsistency
        do_reset();
        raw_s2 = 1;
        tick(9);  chk("s2_edge9", 7'b0000001);
        tick(1);  chk("s2_edge10", 7'b0100001);
        tick(15); chk("finf_edge25", 7'b0100001);
        tick(1);  chk("finf_edge26", SAFE ? 7'b1111100 : 7'b0100100);
        clr_fault = 1; tick(1); clr_fault = 0;
        chk("finf_clr_ignored", SAFE ? 7'b1111100 : 7'b0100100);
        raw_s2 = 0;
        tick(10); chk("finf_consistent", SAFE ? 7'b1111100 : 7'b0000100);
        clr_fault = 1; tick(1); clr_fault = 0;
        chk("finf_cleared", 7'b0000001);
        clr_fault = 1; tick(1); clr_fault = 0;
        chk("clr_nofault", 7'b0000001);

        // 5: upper-tank inconsistency and safe forcing
        do_reset();
        raw_s4 = 1;
        tick(10); chk("s4_edge10", 7'b0001001);
        tick(15); chk("fsup_edge25", 7'b0001001);
        tick(1);  chk("fsup_edge26", SAFE ? 7'b1111010 : 7'b0001010);
        raw_s4 = 0;
        tick(10); chk("fsup_consistent", SAFE ? 7'b1111010 : 7'b0000010);
        clr_fault = 1; tick(1); clr_fault = 0;
        chk("fsup_cleared", 7'b0000001);

        // 6: reset mid-debounce discards progress
        do_reset();
        raw_s1 = 1;
        tick(6);
        rst = 1; #1;
        chk("mid_rst_async", 7'b0000001);
        tick(2);  chk("mid_rst_hold", 7'b0000001);
        rst = 0;
        tick(9);  chk("rerst_edge9", 7'b0000001);
        tick(1);  chk("rerst_edge10", 7'b1000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
